// File: rtl/div_restoring_if.sv
// Operand/result bundle for the multicycle divider.
interface div_restoring_if #(
  parameter int unsigned WIDTH = 32
);
  logic             ctrl_div;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_remainder;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  // Requester side (ALU/multdiv issue logic)
  modport master (
    output ctrl_div, data_operandA, data_operandB,
    input  data_result, data_remainder, data_exception, data_resultRDY, busy
  );

  // Divider side
  modport slave (
    input  ctrl_div, data_operandA, data_operandB,
    output data_result, data_remainder, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/div_restoring.sv
// Signed restoring divider: one quotient bit per clock, truncating quotient,
// remainder signed like the dividend, flags divide-by-zero and overflow.
module div_restoring #(
  parameter int unsigned WIDTH = 32
) (
  input  logic            clock,
  input  logic            reset,
  div_restoring_if.slave  bus
);
  localparam int unsigned W  = WIDTH;
  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    q_q, q_d;          // dividend magnitude shifting out, quotient shifting in
  logic [W-1:0]    r_q, r_d;          // partial remainder, always < |B| between iterations
  logic [W-1:0]    b_q, b_d;          // divisor magnitude
  logic [W-1:0]    a_raw_q, a_raw_d;  // untouched dividend for the divide-by-zero remainder
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_q_q, sign_q_d;
  logic            sign_r_q, sign_r_d;
  logic            zero_q, zero_d;
  logic            ovf_q, ovf_d;
  logic [W-1:0]    result_q, result_d;
  logic [W-1:0]    rem_q, rem_d;
  logic            exc_q, exc_d;
  logic            rdy_q, rdy_d;
  logic            busy_q, busy_d;

  logic [W:0]      r_sh;
  logic [W:0]      trial;
  logic [W-1:0]    a_in, b_in;

  assign a_in = bus.data_operandA;
  assign b_in = bus.data_operandB;

  // One restoring step: shift {R,Q} left and trial-subtract |B| in W+1 bits
  always_comb begin
    r_sh  = {r_q, q_q[W-1]};
    trial = r_sh + (~{1'b0, b_q}) + (W+1)'(1);
  end

  // Next-state and datapath/output updates
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    r_d      = r_q;
    b_d      = b_q;
    a_raw_d  = a_raw_q;
    cnt_d    = cnt_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    rem_d    = rem_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.ctrl_div) begin
          q_d      = a_in[W-1] ? W'(-a_in) : a_in;
          b_d      = b_in[W-1] ? W'(-b_in) : b_in;
          a_raw_d  = a_in;
          r_d      = '0;
          cnt_d    = '0;
          sign_q_d = a_in[W-1] ^ b_in[W-1];
          sign_r_d = a_in[W-1];
          zero_d   = (b_in == '0);
          ovf_d    = (a_in == {1'b1, {(W-1){1'b0}}}) && (b_in == '1);
          state_d  = (b_in == '0) ? FIX : RUN;
        end
      end
      RUN: begin
        if (!trial[W]) begin
          r_d = trial[W-1:0];
          q_d = {q_q[W-2:0], 1'b1};
        end else begin
          r_d = r_sh[W-1:0];
          q_d = {q_q[W-2:0], 1'b0};
        end
        if (cnt_q == CW'(W-1)) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIX: begin
        if (zero_q) begin
          result_d = '0;
          rem_d    = a_raw_q;
          exc_d    = 1'b1;
        end else begin
          result_d = sign_q_q ? W'(-q_q) : q_q;
          rem_d    = sign_r_q ? W'(-r_q) : r_q;
          exc_d    = ovf_q;
        end
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      q_q      <= '0;
      r_q      <= '0;
      b_q      <= '0;
      a_raw_q  <= '0;
      cnt_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      rem_q    <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      r_q      <= r_d;
      b_q      <= b_d;
      a_raw_q  <= a_raw_d;
      cnt_q    <= cnt_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_remainder = rem_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;
endmodule

// File: tb/tb_div_restoring.sv
// Directed bench for div_restoring: signs, latency, exceptions, abort, back-to-back.
module tb_div_restoring;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  div_restoring_if #(.WIDTH(32)) bus ();

  div_restoring #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Issue one operation, return observed outputs at the RDY cycle
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic [31:0] rem,
                        output logic exc, output int lat, output int busy_cnt);
    @(negedge clock);
    bus.ctrl_div = 1'b1; bus.data_operandA = a; bus.data_operandB = b;
    @(posedge clock); #1;
    bus.ctrl_div = 1'b0;
    lat = 0; busy_cnt = 0;
    while (bus.data_resultRDY !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(posedge clock); #1;
      lat++;
    end
    res = bus.data_result; rem = bus.data_remainder; exc = bus.data_exception;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ctrl_div = 1'b0; bus.data_operandA = '0; bus.data_operandB = '0;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if ({bus.data_result, bus.data_remainder, bus.data_exception, bus.data_resultRDY, bus.busy} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got res=%h rem=%h exc=%b rdy=%b busy=%b, want all 0",
               bus.data_result, bus.data_remainder, bus.data_exception, bus.data_resultRDY, bus.busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] res, rem; logic exc; int lat, bc;
    run_op(32'd100, 32'd7, res, rem, exc, lat, bc);
    n_cmp++; if (res !== 32'd14) begin n_fail++; $display("FAIL basic_res: got %h want %h", res, 32'd14); end
    n_cmp++; if (rem !== 32'd2) begin n_fail++; $display("FAIL basic_rem: got %h want %h", rem, 32'd2); end
    n_cmp++; if (exc !== 1'b0) begin n_fail++; $display("FAIL basic_exc: got %b want 0", exc); end
    n_cmp++; if (lat != 33) begin n_fail++; $display("FAIL basic_latency: got %0d want 33", lat); end
    n_cmp++; if (bc != 33) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 33", bc); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_in_rdy: got %b want 0", bus.busy); end
    @(posedge clock); #1;
    n_cmp++; if (bus.data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL basic_rdy_width: got %b want 0", bus.data_resultRDY); end
  endtask

  task automatic test_signs();
    logic [31:0] va [3] = '{32'hFFFFFF9C, 32'd100,     32'hFFFFFF9C};
    logic [31:0] vb [3] = '{32'd7,        32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] eq [3] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14};
    logic [31:0] er [3] = '{32'hFFFFFFFE, 32'd2,        32'hFFFFFFFE};
    logic [31:0] res, rem; logic exc; int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], res, rem, exc, lat, bc);
      n_cmp++;
      if (res !== eq[i] || rem !== er[i] || exc !== 1'b0 || lat != 33) begin
        n_fail++;
        $display("FAIL signs_%0d: got res=%h rem=%h exc=%b lat=%0d want res=%h rem=%h exc=0 lat=33",
                 i, res, rem, exc, lat, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] res, rem; logic exc; int lat, bc;
    run_op(32'd5, 32'd0, res, rem, exc, lat, bc);
    n_cmp++;
    if (res !== 32'd0 || rem !== 32'd5 || exc !== 1'b1 || lat != 1) begin
      n_fail++;
      $display("FAIL div_zero: got res=%h rem=%h exc=%b lat=%0d want res=0 rem=5 exc=1 lat=1", res, rem, exc, lat);
    end
    run_op(32'd6, 32'd3, res, rem, exc, lat, bc);
    n_cmp++;
    if (res !== 32'd2 || rem !== 32'd0 || exc !== 1'b0 || lat != 33) begin
      n_fail++;
      $display("FAIL after_zero: got res=%h rem=%h exc=%b lat=%0d want res=2 rem=0 exc=0 lat=33", res, rem, exc, lat);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] res, rem; logic exc; int lat, bc;
    run_op(32'h80000000, 32'hFFFFFFFF, res, rem, exc, lat, bc);
    n_cmp++;
    if (res !== 32'h80000000 || rem !== 32'd0 || exc !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: got res=%h rem=%h exc=%b want res=80000000 rem=0 exc=1", res, rem, exc);
    end
    run_op(32'h80000000, 32'd1, res, rem, exc, lat, bc);
    n_cmp++;
    if (res !== 32'h80000000 || rem !== 32'd0 || exc !== 1'b0) begin
      n_fail++;
      $display("FAIL min_by_one: got res=%h rem=%h exc=%b want res=80000000 rem=0 exc=0", res, rem, exc);
    end
  endtask

  task automatic test_ignore_and_abort();
    logic [31:0] res, rem; logic exc; int lat, bc; int rdy_seen;
    // Start 1000/10, pulse 9/3 mid-run
    @(negedge clock);
    bus.ctrl_div = 1'b1; bus.data_operandA = 32'd1000; bus.data_operandB = 32'd10;
    @(posedge clock); #1;
    bus.ctrl_div = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    bus.ctrl_div = 1'b1; bus.data_operandA = 32'd9; bus.data_operandB = 32'd3;
    @(posedge clock); #1;
    bus.ctrl_div = 1'b0;
    lat = 0;
    while (bus.data_resultRDY !== 1'b1 && lat < 100) begin @(posedge clock); #1; lat++; end
    n_cmp++;
    if (bus.data_result !== 32'd100 || bus.data_remainder !== 32'd0 || lat != 27) begin
      n_fail++;
      $display("FAIL ignore_busy_start: got res=%h rem=%h wait=%0d want res=64 rem=0 wait=27",
               bus.data_result, bus.data_remainder, lat);
    end
    // Start again and abort with reset at iteration 10
    @(negedge clock);
    bus.ctrl_div = 1'b1; bus.data_operandA = 32'd1000; bus.data_operandB = 32'd10;
    @(posedge clock); #1;
    bus.ctrl_div = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_cmp++;
    if ({bus.data_result, bus.data_remainder, bus.data_exception, bus.data_resultRDY, bus.busy} !== 67'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: got res=%h rem=%h exc=%b rdy=%b busy=%b want all 0",
               bus.data_result, bus.data_remainder, bus.data_exception, bus.data_resultRDY, bus.busy);
    end
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (bus.data_resultRDY === 1'b1 || bus.busy === 1'b1) rdy_seen++;
    end
    n_cmp++;
    if (rdy_seen != 0) begin n_fail++; $display("FAIL abort_no_rdy: got %0d active cycles want 0", rdy_seen); end
    run_op(32'd9, 32'd3, res, rem, exc, lat, bc);
    n_cmp++;
    if (res !== 32'd3 || rem !== 32'd0 || exc !== 1'b0 || lat != 33) begin
      n_fail++;
      $display("FAIL after_abort: got res=%h rem=%h exc=%b lat=%0d want res=3 rem=0 exc=0 lat=33", res, rem, exc, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res, rem; logic exc; int lat, bc; int hold_bad;
    run_op(32'd100, 32'd7, res, rem, exc, lat, bc);
    // Still in the RDY cycle: issue the next operation immediately
    bus.ctrl_div = 1'b1; bus.data_operandA = 32'd50; bus.data_operandB = 32'd8;
    @(posedge clock); #1;
    bus.ctrl_div = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy got %b want 1", bus.busy); end
    lat = 0; hold_bad = 0;
    while (bus.data_resultRDY !== 1'b1 && lat < 100) begin
      if (bus.data_result !== 32'd14 || bus.data_remainder !== 32'd2) hold_bad++;
      @(posedge clock); #1;
      lat++;
    end
    n_cmp++;
    if (hold_bad != 0) begin n_fail++; $display("FAIL b2b_hold: got %0d cycles with changed outputs want 0", hold_bad); end
    n_cmp++;
    if (bus.data_result !== 32'd6 || bus.data_remainder !== 32'd2 || lat != 33) begin
      n_fail++;
      $display("FAIL b2b_result: got res=%h rem=%h lat=%0d want res=6 rem=2 lat=33",
               bus.data_result, bus.data_remainder, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_overflow();
    test_ignore_and_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
